// File: rtl/niosii_system_sysid_checker.sv
// Boot-time system ID integrity checker.
// Acts as a tiny Avalon-MM read master: reads the sysid ID word (addr 0) and,
// when SYSID_CHECK_TS_EN is defined, the timestamp word (addr 1). It compares
// them against build-time constants and publishes a registered pass/fail verdict.
// Without SYSID_CHECK_TS_EN the timestamp read is not built, ts_ok is tied
// high and captured_ts is tied to zero.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h588D_1A01,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int          READ_LATENCY   = 0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_ID  = 3'd1;
  localparam logic [2:0] S_LAT_ID = 3'd2;
  localparam logic [2:0] S_RD_TS  = 3'd3;
  localparam logic [2:0] S_LAT_TS = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Last latency-count value before the data word is valid.
  localparam logic [1:0] LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  logic [2:0]  state;
  logic [15:0] stall_cnt;
  logic [1:0]  lat_cnt;
  logic        auto_pend;

  logic rd_state, lat_state, accept, stall_hit, cap, cap_id, id_hit;

`ifdef SYSID_CHECK_TS_EN
  logic        ts_ok_q;
  logic [31:0] cap_ts_q;
  logic        cap_ts, ts_hit;
  assign ts_ok       = ts_ok_q;
  assign captured_ts = cap_ts_q;
`else
  logic unused_ts;
  assign unused_ts   = ^EXPECTED_TS;
  assign ts_ok       = 1'b1;
  assign captured_ts = '0;
`endif

  // Outputs decode purely from state flops; no input reaches an output combinationally.
  assign m_read = rd_state;
  assign busy   = (state != S_IDLE) && (state != S_DONE);

  // Handshake, timeout and capture qualifiers for the current cycle.
  always_comb begin
    rd_state  = (state == S_RD_ID) || (state == S_RD_TS);
    lat_state = (state == S_LAT_ID) || (state == S_LAT_TS);
    accept    = rd_state && !m_waitrequest;
    // Stall number TIMEOUT_CYCLES ends the read instead of being counted.
    stall_hit = rd_state && m_waitrequest && (stall_cnt == TIMEOUT_CYCLES - 16'd1);
    cap       = (accept && (READ_LATENCY == 0)) || (lat_state && (lat_cnt == LAT_LAST));
    cap_id    = cap && ((state == S_RD_ID) || (state == S_LAT_ID));
    id_hit    = (m_readdata == EXPECTED_ID);
`ifdef SYSID_CHECK_TS_EN
    cap_ts    = cap && ((state == S_RD_TS) || (state == S_LAT_TS));
    ts_hit    = (m_readdata == EXPECTED_TS);
`endif
  end

  // Check sequencer: request, wait out latency, capture, verdict.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      m_address   <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      stall_cnt   <= '0;
      lat_cnt     <= '0;
      auto_pend   <= AUTO_START;
`ifdef SYSID_CHECK_TS_EN
      ts_ok_q     <= 1'b0;
      cap_ts_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (rd_state && m_waitrequest && !stall_hit) stall_cnt <= stall_cnt + 16'd1;
      if (lat_state) lat_cnt <= lat_cnt + 2'd1;
      if (cap_id) begin
        captured_id <= m_readdata;
        id_ok       <= id_hit;
      end
`ifdef SYSID_CHECK_TS_EN
      if (cap_ts) begin
        cap_ts_q <= m_readdata;
        ts_ok_q  <= ts_hit;
      end
`endif
      case (state)
        S_IDLE: begin
          if (start || auto_pend) begin
            state     <= S_RD_ID;
            auto_pend <= 1'b0;
            m_address <= 1'b0;
            stall_cnt <= '0;
            id_ok     <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
`ifdef SYSID_CHECK_TS_EN
            ts_ok_q   <= 1'b0;
`endif
          end
        end
        S_RD_ID, S_LAT_ID: begin
          if (stall_hit) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (cap_id) begin
`ifdef SYSID_CHECK_TS_EN
            state     <= S_RD_TS;
            m_address <= 1'b1;
            stall_cnt <= '0;
`else
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= id_hit;
`endif
          end else if (accept) begin
            state   <= S_LAT_ID;
            lat_cnt <= '0;
          end
        end
`ifdef SYSID_CHECK_TS_EN
        S_RD_TS, S_LAT_TS: begin
          if (stall_hit) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (cap_ts) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= id_ok && ts_hit;
          end else if (accept) begin
            state   <= S_LAT_TS;
            lat_cnt <= '0;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for niosii_system_sysid_checker. u0: zero read latency,
// TIMEOUT_CYCLES=8, auto-start. u2: READ_LATENCY=2 with a pipelined slave model
// that drives junk outside the valid data slot.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h588D_1A01;
`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN    = 1'b1;
  localparam int DONE_CYC = 3;
  localparam int LAT_DONE = 12;
  localparam int RST_CYC  = 2;
`else
  localparam bit TS_EN    = 1'b0;
  localparam int DONE_CYC = 2;
  localparam int LAT_DONE = 9;
  localparam int RST_CYC  = 1;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic start0 = 1'b0, start2 = 1'b0, wait0 = 1'b0, wait2 = 1'b0;
  logic [31:0] id_val0 = EXP_ID, ts_val0 = 32'h0;
  logic [31:0] rdata0, rdata2;
  logic m_read0, m_addr0, busy0, done0, pass0, id_ok0, ts_ok0, to0;
  logic m_read2, m_addr2, busy2, done2, pass2, id_ok2, ts_ok2, to2;
  logic [31:0] cid0, cts0, cid2, cts2;
  logic [1:0] pv = '0, pa = '0;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  // Zero-latency slave: data follows the address.
  assign rdata0 = m_addr0 ? ts_val0 : id_val0;

  // Two-cycle-latency slave: data valid exactly two edges after acceptance.
  always @(posedge clk) begin
    pv <= {pv[0], m_read2 && !wait2};
    pa <= {pa[0], m_addr2};
  end
  assign rdata2 = pv[1] ? (pa[1] ? 32'h0 : EXP_ID) : 32'hBAD0_0BAD;

  niosii_system_sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(16'd8), .AUTO_START(1'b1)) u0 (
    .clock(clk), .reset(reset), .start(start0), .m_address(m_addr0), .m_read(m_read0),
    .m_waitrequest(wait0), .m_readdata(rdata0), .busy(busy0), .done(done0), .pass(pass0),
    .id_ok(id_ok0), .ts_ok(ts_ok0), .timeout(to0), .captured_id(cid0), .captured_ts(cts0));

  niosii_system_sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(16'd16), .AUTO_START(1'b0)) u2 (
    .clock(clk), .reset(reset), .start(start2), .m_address(m_addr2), .m_read(m_read2),
    .m_waitrequest(wait2), .m_readdata(rdata2), .busy(busy2), .done(done2), .pass(pass2),
    .id_ok(id_ok2), .ts_ok(ts_ok2), .timeout(to2), .captured_id(cid2), .captured_ts(cts2));

  // Called on the negedge where start0 was driven; returns the cycle of done0, -1 if none.
  task automatic wait_done0(input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0) begin cyc = c; break; end
    end
  endtask

  task automatic test_reset;
    int cyc;
    repeat (3) @(negedge clk);
    n_total++;
    if ({m_read0, busy0, done0, pass0, id_ok0, to0, m_addr0, ts_ok0} !== {7'b0, ~TS_EN})
      $display("FAIL reset_flags0: got %b expected %b",
               {m_read0, busy0, done0, pass0, id_ok0, to0, m_addr0, ts_ok0}, {7'b0, ~TS_EN});
    else n_pass++;
    n_total++;
    if ({cid0, cts0} !== 64'h0) $display("FAIL reset_captures0: got %h expected 0", {cid0, cts0});
    else n_pass++;
    n_total++;
    if ({m_read2, busy2, done2, pass2} !== 4'b0) $display("FAIL reset_flags2: got %b expected 0000", {m_read2, busy2, done2, pass2});
    else n_pass++;
    reset = 1'b0;
    wait_done0(20, cyc);
    n_total++;
    if (cyc !== DONE_CYC) $display("FAIL auto_start_done_cycle: got %0d expected %0d", cyc, DONE_CYC);
    else n_pass++;
    n_total++;
    if (pass0 !== 1'b1) $display("FAIL auto_start_pass: got %b expected 1", pass0);
    else n_pass++;
  endtask

  task automatic test_best_case;
    int dcyc, nbusy;
    bit saw1;
    dcyc = -1; nbusy = 0; saw1 = 1'b0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n_total++;
    if ({m_read0, m_addr0, busy0} !== 3'b101) $display("FAIL best_cycle1_id_read: got %b expected 101", {m_read0, m_addr0, busy0});
    else n_pass++;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (busy0) nbusy++;
      if (m_read0 && m_addr0) saw1 = 1'b1;
      if (done0) begin dcyc = c; break; end
    end
    n_total++;
    if (dcyc !== DONE_CYC) $display("FAIL best_done_cycle: got %0d expected %0d", dcyc, DONE_CYC);
    else n_pass++;
    n_total++;
    if (nbusy !== DONE_CYC - 1) $display("FAIL best_busy_cycles: got %0d expected %0d", nbusy, DONE_CYC - 1);
    else n_pass++;
    n_total++;
    if (saw1 !== TS_EN) $display("FAIL best_ts_read_seen: got %b expected %b", saw1, TS_EN);
    else n_pass++;
    n_total++;
    if ({pass0, id_ok0, ts_ok0, to0} !== 4'b1110) $display("FAIL best_verdict: got %b expected 1110", {pass0, id_ok0, ts_ok0, to0});
    else n_pass++;
    n_total++;
    if (cid0 !== EXP_ID) $display("FAIL best_captured_id: got %h expected %h", cid0, EXP_ID);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done0 !== 1'b0) $display("FAIL best_done_single_pulse: got %b expected 0", done0);
    else n_pass++;
  endtask

  task automatic test_bad_id;
    int cyc;
    id_val0 = 32'hDEAD_BEEF;
    @(negedge clk) start0 = 1'b1;
    wait_done0(20, cyc);
    n_total++;
    if (cyc !== DONE_CYC) $display("FAIL bad_id_done_cycle: got %0d expected %0d", cyc, DONE_CYC);
    else n_pass++;
    n_total++;
    if ({pass0, id_ok0, ts_ok0, to0} !== 4'b0010) $display("FAIL bad_id_verdict: got %b expected 0010", {pass0, id_ok0, ts_ok0, to0});
    else n_pass++;
    n_total++;
    if (cid0 !== 32'hDEAD_BEEF) $display("FAIL bad_id_captured: got %h expected deadbeef", cid0);
    else n_pass++;
    id_val0 = EXP_ID;
  endtask

  task automatic test_bad_ts;
    int cyc;
    ts_val0 = 32'h5EED_0001;
    @(negedge clk) start0 = 1'b1;
    wait_done0(20, cyc);
    n_total++;
    if ({pass0, id_ok0, ts_ok0, to0} !== (TS_EN ? 4'b0100 : 4'b1110))
      $display("FAIL bad_ts_verdict: got %b expected %b", {pass0, id_ok0, ts_ok0, to0}, (TS_EN ? 4'b0100 : 4'b1110));
    else n_pass++;
    n_total++;
    if (cts0 !== (TS_EN ? 32'h5EED_0001 : 32'h0)) $display("FAIL bad_ts_captured: got %h expected %h", cts0, (TS_EN ? 32'h5EED_0001 : 32'h0));
    else n_pass++;
    ts_val0 = 32'h0;
  endtask

  task automatic test_latency_stall;
    int dcyc;
    bit stable;
    dcyc = -1; stable = 1'b1;
    @(negedge clk) begin start2 = 1'b1; wait2 = 1'b1; end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      wait2 = (c <= 5);
      if (c <= 6 && !(m_read2 && !m_addr2)) stable = 1'b0;
      if (c == 7 && m_read2) stable = 1'b0;
      if (done2) begin dcyc = c; break; end
    end
    wait2 = 1'b0;
    n_total++;
    if (stable !== 1'b1) $display("FAIL lat_request_hold: got %b expected 1", stable);
    else n_pass++;
    n_total++;
    if (dcyc !== LAT_DONE) $display("FAIL lat_done_cycle: got %0d expected %0d", dcyc, LAT_DONE);
    else n_pass++;
    n_total++;
    if ({pass2, id_ok2, ts_ok2, to2} !== 4'b1110) $display("FAIL lat_verdict: got %b expected 1110", {pass2, id_ok2, ts_ok2, to2});
    else n_pass++;
    n_total++;
    if (cid2 !== EXP_ID) $display("FAIL lat_captured_id: got %h expected %h", cid2, EXP_ID);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int nrd, ndone, dcyc;
    logic [3:0] v;
    nrd = 0; ndone = 0; dcyc = -1; v = 4'hx;
    wait0 = 1'b1;
    @(negedge clk) start0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (m_read0) nrd++;
      if (done0) begin
        ndone++;
        if (ndone == 1) begin dcyc = c; v = {pass0, id_ok0, ts_ok0, to0}; end
      end
    end
    wait0 = 1'b0;
    n_total++;
    if (nrd !== 8) $display("FAIL timeout_read_cycles: got %0d expected 8", nrd);
    else n_pass++;
    n_total++;
    if (ndone !== 1 || dcyc !== 9) $display("FAIL timeout_done: got %0d pulses at %0d expected 1 at 9", ndone, dcyc);
    else n_pass++;
    n_total++;
    if (v !== {2'b00, ~TS_EN, 1'b1}) $display("FAIL timeout_verdict: got %b expected %b", v, {2'b00, ~TS_EN, 1'b1});
    else n_pass++;
  endtask

  task automatic test_boundary;
    int dcyc;
    dcyc = -1;
    wait0 = 1'b1;
    @(negedge clk) start0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      wait0 = (c <= 7);
      if (done0) begin dcyc = c; break; end
    end
    wait0 = 1'b0;
    n_total++;
    if (dcyc !== DONE_CYC + 7) $display("FAIL boundary_done_cycle: got %0d expected %0d", dcyc, DONE_CYC + 7);
    else n_pass++;
    n_total++;
    if ({pass0, to0} !== 2'b10) $display("FAIL boundary_verdict: got %b expected 10", {pass0, to0});
    else n_pass++;
  endtask

  task automatic test_start_while_busy;
    int ndone;
    ndone = 0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b1;
    if (done0) ndone++;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0) ndone++;
    end
    n_total++;
    if (ndone !== 1) $display("FAIL busy_start_ignored: got %0d done pulses expected 1", ndone);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk) begin start0 = 1'b1; wait0 = 1'b0; end
    for (int c = 1; c <= RST_CYC; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (c == RST_CYC) wait0 = 1'b1;
    end
    n_total++;
    if ({m_read0, m_addr0} !== {1'b1, TS_EN}) $display("FAIL mid_precondition: got %b expected %b", {m_read0, m_addr0}, {1'b1, TS_EN});
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({m_read0, busy0, done0, pass0, id_ok0, to0, m_addr0, ts_ok0} !== {7'b0, ~TS_EN})
      $display("FAIL mid_reset_flags: got %b expected %b",
               {m_read0, busy0, done0, pass0, id_ok0, to0, m_addr0, ts_ok0}, {7'b0, ~TS_EN});
    else n_pass++;
    reset = 1'b0;
    wait0 = 1'b0;
    wait_done0(20, cyc);
    n_total++;
    if (cyc !== DONE_CYC) $display("FAIL mid_restart_done_cycle: got %0d expected %0d", cyc, DONE_CYC);
    else n_pass++;
    n_total++;
    if (pass0 !== 1'b1) $display("FAIL mid_restart_pass: got %b expected 1", pass0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_best_case();
    test_bad_id();
    test_bad_ts();
    test_latency_stall();
    test_timeout();
    test_boundary();
    test_start_while_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
